seq_det_ctrl: RTL

SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

---
 rtl/seq_det_pkg.sv | 31 +++
 rtl/seq_1011_core.sv | 30 +++
 rtl/seq_det_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared encodings for the 1011 sequence-detect controller.
package seq_det_pkg;

  // Controller FSM encoding
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Detector encoding: Sn = n leading pattern bits seen so far
  localparam logic [1:0] DS_S0 = 2'd0;
  localparam logic [1:0] DS_S1 = 2'd1;
  localparam logic [1:0] DS_S2 = 2'd2;
  localparam logic [1:0] DS_S3 = 2'd3;

  // Pattern searched for, first received bit in the MSB
  localparam logic [3:0] PATTERN = 4'b1011;

  // Next detector state for one received bit (overlapping matches allowed)
  function automatic logic [1:0] det_next(input logic [1:0] s, input logic b);
    logic [1:0] n;
    n = DS_S0;
    case (s)
      DS_S0:   n = b ? DS_S1 : DS_S0;
      DS_S1:   n = b ? DS_S1 : DS_S2;
      DS_S2:   n = b ? DS_S3 : DS_S0;
      DS_S3:   n = b ? DS_S1 : DS_S2;
      default: n = DS_S0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/seq_1011_core.sv
// Mealy detector for the pattern 1011; advances only on qualified bits.
//
// state | meaning
// S0    | no useful prefix
// S1    | seen "1"
// S2    | seen "10"
// S3    | seen "101" (a following 1 is a match)
module seq_1011_core
  import seq_det_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic bit_valid,
  input  logic in_bit,
  output logic match
);

  logic [1:0] r_state;

  // Detector state; clear wins so the next bit starts from S0
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_state <= DS_S0;
    else if (clear)     r_state <= DS_S0;
    else if (bit_valid) r_state <= det_next(r_state, in_bit);
  end

  assign match = bit_valid & (r_state == DS_S3) & (in_bit == PATTERN[0]);

endmodule

// File: rtl/seq_det_ctrl.sv
// Word-to-bit serializer feeding the 1011 detector, with saturating match
// counter and sticky threshold interrupt.
//
// state | meaning
// IDLE  | no word held, ready whenever enabled
// SHIFT | presenting shreg MSB each enabled cycle; reloads on the last bit
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              clear_det,
  input  logic              clear_cnt,
  input  logic [CNT_W-1:0]  thresh,
  output logic              busy,
  output logic              match_pulse,
  output logic [CNT_W-1:0]  match_count,
  output logic              irq
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [0:0]        r_state;
  logic [DATA_W-1:0] r_shreg;
  logic [IDX_W-1:0]  r_idx;
  logic              r_match_pulse;
  logic [CNT_W-1:0]  r_match_count;
  logic              r_irq;

  logic             w_last;
  logic             w_ready;
  logic             w_load;
  logic             w_bit_valid;
  logic             w_match;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_last      = (r_state == ST_SHIFT) && (r_idx == LAST_IDX);
  assign w_ready     = enable & ((r_state == ST_IDLE) | w_last);
  assign w_load      = in_valid & w_ready;
  assign w_bit_valid = enable & (r_state == ST_SHIFT);
  assign w_cnt_inc   = r_match_count + 1'b1;

  // Serializer: load on handshake (including the last bit, so no bubble), else shift
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_shreg <= '0;
      r_idx   <= '0;
    end else if (enable) begin
      if (w_load) begin
        r_state <= ST_SHIFT;
        r_shreg <= in_data;
        r_idx   <= '0;
      end else if (r_state == ST_SHIFT) begin
        if (w_last) r_state <= ST_IDLE;
        r_shreg <= r_shreg << 1;
        r_idx   <= w_last ? '0 : r_idx + 1'b1;
      end
    end
  end

  seq_1011_core u_core (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear_det),
    .bit_valid (w_bit_valid),
    .in_bit    (r_shreg[DATA_W-1]),
    .match     (w_match)
  );

  // Match pulse, saturating count and sticky irq; clear_cnt beats a match
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_match_pulse <= 1'b0;
      r_match_count <= '0;
      r_irq         <= 1'b0;
    end else begin
      r_match_pulse <= w_match;
      if (clear_cnt) begin
        r_match_count <= '0;
        r_irq         <= 1'b0;
      end else if (w_match && (r_match_count != CNT_MAX)) begin
        r_match_count <= w_cnt_inc;
        if ((thresh != '0) && (w_cnt_inc == thresh)) r_irq <= 1'b1;
      end
    end
  end

  assign in_ready    = w_ready;
  assign busy        = (r_state == ST_SHIFT);
  assign match_pulse = r_match_pulse;
  assign match_count = r_match_count;
  assign irq         = r_irq;

endmodule
